// File: rtl/usr_amm_stat_csr_if.sv
// usr_amm_stat_csr_if: single-cycle CSR port of the DFX statistics block.
// master = register bank side issuing accesses, slave = usr_amm_stat_csr.
interface usr_amm_stat_csr_if;
    logic        csr_wr;
    logic        csr_rd;
    logic [3:0]  csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_rvld;

    modport master (
        output csr_wr,
        output csr_rd,
        output csr_addr,
        output csr_wdata,
        input  csr_rdata,
        input  csr_rvld
    );

    modport slave (
        input  csr_wr,
        input  csr_rd,
        input  csr_addr,
        input  csr_wdata,
        output csr_rdata,
        output csr_rvld
    );
endinterface

// File: rtl/usr_amm_stat_csr.sv
// usr_amm_stat_csr: glitch-filtered Avalon-MM DFX counters exposed as
// snapshots, per-window deltas, outstanding read beats and a watermark.
// Optional feature: define USR_AMM_STAT_WMARK_EN to build the outstanding
// watermark register (0x9) and its clear (CTRL bit1).
module usr_amm_stat_csr #(
    parameter logic [31:0] WIN_CYC_DFLT = 32'd100_000_000,
    parameter int unsigned BURST_LEN    = 1
) (
    input  logic              usr_clk,
    input  logic              rst,
    input  logic [31:0]       amm_wr_cmd_cnt,
    input  logic [31:0]       amm_rd_cmd_cnt,
    input  logic [31:0]       amm_rd_data_cnt,
    usr_amm_stat_csr_if.slave csr
);

    localparam int unsigned   DW      = 32;
    localparam logic [DW-1:0] BURST_W = DW'(BURST_LEN);

    localparam logic [3:0] A_CTRL      = 4'h0;
    localparam logic [3:0] A_WIN_CYC   = 4'h1;
    localparam logic [3:0] A_SNAP_WR   = 4'h2;
    localparam logic [3:0] A_SNAP_RD   = 4'h3;
    localparam logic [3:0] A_SNAP_RDAT = 4'h4;
    localparam logic [3:0] A_WIN_WR    = 4'h5;
    localparam logic [3:0] A_WIN_RD    = 4'h6;
    localparam logic [3:0] A_WIN_RDAT  = 4'h7;
    localparam logic [3:0] A_OUTST     = 4'h8;
    localparam logic [3:0] A_WMARK     = 4'h9;

    logic [DW-1:0] raw_wr, raw_rd, raw_rdat;
    logic [DW-1:0] filt_wr, filt_rd, filt_rdat;
    logic [DW-1:0] snap_wr, snap_rd, snap_rdat;
    logic [DW-1:0] base_wr, base_rd, base_rdat;
    logic [DW-1:0] win_wr, win_rd, win_rdat;
    logic [DW-1:0] win_cyc, win_cnt;
    logic          win_vld;
    logic [DW-1:0] outst;
    logic [DW-1:0] wmark;

    logic          wr_ctrl_c, wr_win_cyc_c, rd_ctrl_c, win_end_c;
    logic [DW-1:0] rd_mux_c;

    // Access decode and window-end detect; a WIN_CYC write restarts the window instead.
    always_comb begin
        wr_ctrl_c    = csr.csr_wr && (csr.csr_addr == A_CTRL);
        wr_win_cyc_c = csr.csr_wr && (csr.csr_addr == A_WIN_CYC);
        rd_ctrl_c    = csr.csr_rd && (csr.csr_addr == A_CTRL);
        win_end_c    = (win_cyc != '0) && (win_cnt == win_cyc - DW'(1)) && !wr_win_cyc_c;
    end

    // Accept a counter value only once it has been seen on two consecutive edges.
    always_ff @(posedge usr_clk) begin
        if (rst) begin
            raw_wr    <= '0;
            raw_rd    <= '0;
            raw_rdat  <= '0;
            filt_wr   <= '0;
            filt_rd   <= '0;
            filt_rdat <= '0;
        end else begin
            raw_wr   <= amm_wr_cmd_cnt;
            raw_rd   <= amm_rd_cmd_cnt;
            raw_rdat <= amm_rd_data_cnt;
            if (amm_wr_cmd_cnt == raw_wr)   filt_wr   <= amm_wr_cmd_cnt;
            if (amm_rd_cmd_cnt == raw_rd)   filt_rd   <= amm_rd_cmd_cnt;
            if (amm_rd_data_cnt == raw_rdat) filt_rdat <= amm_rd_data_cnt;
        end
    end

    // Coherent snapshot of all three filtered counters on CTRL bit0.
    always_ff @(posedge usr_clk) begin
        if (rst) begin
            snap_wr   <= '0;
            snap_rd   <= '0;
            snap_rdat <= '0;
        end else if (wr_ctrl_c && csr.csr_wdata[0]) begin
            snap_wr   <= filt_wr;
            snap_rd   <= filt_rd;
            snap_rdat <= filt_rdat;
        end
    end

    // Window timer, per-window deltas and the sticky win_vld flag (set beats read-clear).
    always_ff @(posedge usr_clk) begin
        if (rst) begin
            win_cyc   <= WIN_CYC_DFLT;
            win_cnt   <= '0;
            base_wr   <= '0;
            base_rd   <= '0;
            base_rdat <= '0;
            win_wr    <= '0;
            win_rd    <= '0;
            win_rdat  <= '0;
            win_vld   <= 1'b0;
        end else begin
            if (wr_win_cyc_c) begin
                win_cyc   <= csr.csr_wdata;
                win_cnt   <= '0;
                base_wr   <= filt_wr;
                base_rd   <= filt_rd;
                base_rdat <= filt_rdat;
            end else if (win_cyc == '0) begin
                win_cnt <= '0;
            end else if (win_end_c) begin
                win_cnt   <= '0;
                win_wr    <= filt_wr - base_wr;
                win_rd    <= filt_rd - base_rd;
                win_rdat  <= filt_rdat - base_rdat;
                base_wr   <= filt_wr;
                base_rd   <= filt_rd;
                base_rdat <= filt_rdat;
            end else begin
                win_cnt <= win_cnt + DW'(1);
            end

            if (win_end_c) begin
                win_vld <= 1'b1;
            end else if (rd_ctrl_c) begin
                win_vld <= 1'b0;
            end
        end
    end

    // Outstanding read beats: expected beats minus returned beats, modulo 2^32.
    always_ff @(posedge usr_clk) begin
        if (rst) begin
            outst <= '0;
        end else begin
            outst <= (filt_rd * BURST_W) - filt_rdat;
        end
    end

`ifdef USR_AMM_STAT_WMARK_EN
    logic wmark_clr_c;

    // Watermark clear request from CTRL bit1.
    always_comb begin
        wmark_clr_c = wr_ctrl_c && csr.csr_wdata[1];
    end

    // Track the highest outstanding count; clear takes priority for one cycle.
    always_ff @(posedge usr_clk) begin
        if (rst) begin
            wmark <= '0;
        end else if (wmark_clr_c) begin
            wmark <= '0;
        end else if (outst > wmark) begin
            wmark <= outst;
        end
    end
`else
    assign wmark = '0;
`endif

    // Read data select from current (pre-write) register values.
    always_comb begin
        rd_mux_c = '0;
        case (csr.csr_addr)
            A_CTRL:      rd_mux_c = {{(DW-1){1'b0}}, win_vld};
            A_WIN_CYC:   rd_mux_c = win_cyc;
            A_SNAP_WR:   rd_mux_c = snap_wr;
            A_SNAP_RD:   rd_mux_c = snap_rd;
            A_SNAP_RDAT: rd_mux_c = snap_rdat;
            A_WIN_WR:    rd_mux_c = win_wr;
            A_WIN_RD:    rd_mux_c = win_rd;
            A_WIN_RDAT:  rd_mux_c = win_rdat;
            A_OUTST:     rd_mux_c = outst;
            A_WMARK:     rd_mux_c = wmark;
            default:     rd_mux_c = '0;
        endcase
    end

    // Registered read response; rdata holds its last value between reads.
    always_ff @(posedge usr_clk) begin
        if (rst) begin
            csr.csr_rdata <= '0;
            csr.csr_rvld  <= 1'b0;
        end else begin
            csr.csr_rvld <= csr.csr_rd;
            if (csr.csr_rd) begin
                csr.csr_rdata <= rd_mux_c;
            end
        end
    end

endmodule

// File: doc/usr_amm_stat_csr.md
# usr_amm_stat_csr

Consumer of the Avalon-MM DFX counters in the usr_clk domain. Takes the three free-running 32-bit counters (write commands, read commands, read data beats) after their clock crossing, filters out incoherent multi-bit samples, and exposes coherent snapshots, per-window deltas, live outstanding read beats and an outstanding watermark through a single-cycle CSR port. Sits between the DFX counter stage and the user register bank of the DDR test design.

## Interface
- WIN_CYC_DFLT, 32'd100_000_000, reset value of the window length register (usr_clk cycles)
- BURST_LEN, 1, read data beats returned per read command (integer 1..256)
- usr_clk  in  1  block clock
- rst  in  1  reset, synchronous, active-high; clock usr_clk
- amm_wr_cmd_cnt  in  32  write-command count, already in usr_clk domain, may glitch between values
- amm_rd_cmd_cnt  in  32  read-command count, same properties
- amm_rd_data_cnt  in  32  read-data-beat count, same properties
- csr_wr  in  1  register write strobe
- csr_rd  in  1  register read strobe
- csr_addr  in  4  register word address
- csr_wdata  in  32  write data
- csr_rdata  out  32  read data
- csr_rvld  out  1  read data valid

## Operation
- Filter, per counter: raw_q <= input every cycle; filt <= input only when input == raw_q. Filtered values reset to 0.
- Register map (read, write):
  - 0x0 CTRL: read {31'b0, win_vld}, read clears win_vld; write bit0=1 takes snapshot, bit1=1 clears watermark.
  - 0x1 WIN_CYC: RW window length; reset WIN_CYC_DFLT.
  - 0x2/0x3/0x4 SNAP_WR/SNAP_RD/SNAP_RDATA: RO, filtered counts captured by the snapshot, all three in the same cycle.
  - 0x5/0x6/0x7 WIN_WR/WIN_RD/WIN_RDATA: RO, deltas over the last completed window.
  - 0x8 OUTST: RO, live outstanding beats.
  - 0x9 WMARK: RO, maximum OUTST since reset or clear.
  - 0xA-0xF: read 32'h0, writes ignored.
- Window: win_cnt counts 0..WIN_CYC-1. At WIN_CYC-1: WIN_x <= filt_x - base_x (mod 2^32); base_x <= filt_x; win_vld <= 1; win_cnt <= 0.
- WIN_CYC write: win_cnt <= 0, base_x <= filt_x; WIN_x and win_vld unchanged. WIN_CYC = 0 disables windowing (win_cnt held 0, no latch).
- OUTST <= filt_rd * BURST_LEN - filt_rdata, low 32 bits, unsigned wrap.
- WMARK: if OUTST > WMARK (unsigned) WMARK <= OUTST. Clear has priority: WMARK <= 0 that cycle, compare resumes next cycle.
- All RO and state registers reset to 0 except WIN_CYC.

## Timing
- Outputs after rst: csr_rdata = 0, csr_rvld = 0.
- Filter latency: input stable from edge t -> filt updated at edge t+2; a value held for only one cycle is never accepted.
- OUTST lags filt by 1 cycle; WMARK lags OUTST by 1 cycle.
- CSR read: csr_rd at edge t -> csr_rdata/csr_rvld valid for exactly cycle t+1; csr_rdata holds last value when csr_rvld = 0. Reads allowed every cycle.
- Simultaneous csr_rd and csr_wr: both honoured; read returns pre-write value.
- CTRL read in same cycle as window end: win_vld reads its old value and ends 1 (set wins over clear).
- Snapshot write in same cycle as filt update: snapshot takes pre-update filt values.
- rst mid-window or mid-read: all state returns to reset values next edge; a pending csr_rvld is dropped.

## Configuration
- USR_AMM_STAT_WMARK_EN defined: WMARK register and compare logic present as above.
- Not defined: no watermark logic; 0x9 reads 32'h0, CTRL bit1 ignored; OUTST still present.

## Test plan
- Reset: after rst, read 0x1 -> WIN_CYC_DFLT; read 0x2..0x9 -> 0; csr_rvld only cycle after csr_rd.
- Glitch filter: rd_cmd 5 -> single cycle 0xFFFF_0005 -> 6 held; SNAP_RD never shows 0xFFFF_0005, shows 6 two cycles after 6 applied.
- Window wrap: WIN_CYC=10, wr_cmd from 0xFFFF_FFFE incrementing 1/cycle -> WIN_WR = 10, win_vld = 1, CTRL read returns 1 then 0.
- Outstanding: BURST_LEN=4, rd_cmd=3, rd_data=5 -> OUTST = 7, WMARK = 7; rd_data to 12 -> OUTST 0, WMARK 7; CTRL write 2 -> WMARK 0.
- Collisions: CTRL read at window end -> win_vld stays 1; csr_rd+csr_wr to 0x1 with 0x20 -> rdata old value, next read 0x20.
- Macro off: read 0x9 -> 0 regardless of OUTST history.
